data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised, clocked successor to the processor's combinational data memory. It holds a synchronous word array of DATA_W-bit words with a Req/Ready/Done handshake and registered read data. It adds a wide mode that moves a 2*DATA_W value (PC/flags push-pop) as two consecutive words over two cycles, and it flags illegal or out-of-range accesses. It sits in the MEM stage between the ALU result/stack-pointer logic and write-back.

Parameters:
DATA_W, 16, word width in bits
DEPTH, 2048, number of words (valid addresses 0..DEPTH-1)
ADDR_W, 32, width of the Address port; only values < DEPTH are legal

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous active-low reset
Req  in  1  access request, sampled when Ready=1
MemoryRead  in  1  read request qualifier
MemoryWrite  in  1  write request qualifier
Wide  in  1  0 = single word, 1 = double word (two cycles)
Address  in  ADDR_W  word address
DataIn  in  2*DATA_W  write data; single mode uses [DATA_W-1:0]
DataOut  out  2*DATA_W  registered read data
Ready  out  1  controller can accept a request this cycle
Done  out  1  one-cycle pulse: access completed
Error  out  1  one-cycle pulse, coincident with Done: access rejected

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous, active-low, on Rst_n.
- Reset values: state=IDLE, Ready=1, Done=0, Error=0, DataOut=0. The array is not cleared.
- Acceptance: a request is accepted at a rising edge where Req=1, Ready=1 and exactly one of MemoryRead/MemoryWrite is 1.
- Invalid request: if Req=1 and Ready=1 and MemoryRead and MemoryWrite are both 0 or both 1:
  - no array access occurs;
  - Done=1 and Error=1 in the next cycle;
  - DataOut holds its value.
- Range check:
  - single access: Address >= DEPTH is out of range;
  - wide access: Address >= DEPTH-1 is out of range;
  - out-of-range requests are rejected with Done=1 and Error=1 next cycle, no write occurs, and DataOut holds;
  - addresses never wrap.
- FSM states:
  - IDLE: Ready=1.
    - Accept single -> stays IDLE.
    - Accept wide -> SECOND.
  - SECOND: Ready=0; performs the high-word access at Address+1 (latched at accept) -> IDLE.
- Single write: at the accept edge, mem[A] <= DataIn[DATA_W-1:0]. Done=1 the following cycle.
- Single read: at the accept edge, DataOut <= {DATA_W'0, mem[A]}. Done=1 the following cycle, with DataOut valid. Latency is 1.
- Wide write:
  - edge N: mem[A] <= DataIn[DATA_W-1:0];
  - edge N+1: mem[A+1] <= DataIn[2*DATA_W-1:DATA_W];
  - Done=1 after edge N+1.
- Wide read:
  - edge N: DataOut[DATA_W-1:0] <= mem[A];
  - edge N+1: DataOut[2*DATA_W-1:DATA_W] <= mem[A+1];
  - Done=1 after edge N+1. Latency is 2.
- Latching: Address, DataIn, MemoryRead/MemoryWrite and Wide are latched at accept. Input changes during SECOND are ignored.
- Throughput: back-to-back single accesses are allowed, one per cycle. A read issued the cycle after a write to the same address returns the new data.
- Done and Error are single-cycle pulses. Between accesses, DataOut holds the last read value.
- Reset mid-operation: asserting Rst_n=0 during SECOND aborts the access. For a wide write, the low word is already written and the high word is not. Done is not pulsed.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_SECOND) and default DATA_W, DEPTH and ADDR_W constants, reused by instruction memory and the stack unit.
- One sub-module, data_mem_array: DEPTH x DATA_W synchronous single-port array with write enable, registered read, no reset.
- Controller FSM, range check and DataOut assembly live in data_memory_ctrl.

Test Plan:
1. Single write then read:
   - Write 0xFFFF to address 1, then read address 1.
   - Read gives DataOut=0x0000FFFF, Done=1, Error=0, with one-cycle read latency.
2. Overwrite and retention:
   - Write 0x0DDF to 8, 0xEB5A to 2047, 0x1234 to 1.
   - Read 8 gives 0x0DDF; read 2047 gives 0xEB5A; read 1 gives 0x1234.
3. Wide write then read:
   - Wide write 0xAABBCCDD to address 100.
   - Ready=0 for one cycle; mem[100]=0xCCDD and mem[101]=0xAABB.
   - Wide read of 100 returns 0xAABBCCDD, Done two cycles after accept.
4. Range errors:
   - Single read at 2048 -> Error=1 and Done=1; DataOut unchanged.
   - Wide write at 2047 -> Error=1 and mem[2047] unchanged.
5. Illegal request:
   - MemoryRead=MemoryWrite=1 at address 5 -> Error=1 and mem[5] unchanged.
   - MemoryRead=MemoryWrite=0 with Req=1 -> Error=1.
6. Reset mid wide write:
   - Wide write 0x11112222 to 10; assert Rst_n=0 during SECOND.
   - Then mem[10]=0x2222 and mem[11] holds its old value.
   - DataOut=0, Ready=1, and no Done pulse.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared MEM-stage definitions: controller state encoding and default geometry
// reused by the instruction memory and the stack unit.
package data_memory_ctrl_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 2048;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;
endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W single-port synchronous word array with a registered read port.
// Contents are intentionally not reset.
module data_mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2048,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // rdata_q only moves on a read, so it doubles as holding storage for DataOut.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory_ctrl.sv
// Clocked data memory controller: single/wide accesses with Req/Ready/Done
// handshake, range and opcode checking, and held registered read data.
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Req,
  input  logic                MemoryRead,
  input  logic                MemoryWrite,
  input  logic                Wide,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [2*DATA_W-1:0] DataIn,
  output logic [2*DATA_W-1:0] DataOut,
  output logic                Ready,
  output logic                Done,
  output logic                Error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT_SINGLE = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT_WIDE   = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] hi_wdata_q, hi_wdata_d;
  logic              rd_q, rd_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic              lo_sel_q, lo_sel_d, hi_sel_q, hi_sel_d;

  logic              mem_we, mem_re;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] vis_lo, vis_hi;
  logic              op_ok, in_range, accept_ok;

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk_i   (Clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // Each DataOut half shows either the live array read register or a frozen copy;
  // the frozen copy is refreshed just before the array read register is reused.
  assign vis_lo  = lo_sel_q ? mem_rdata : lo_q;
  assign vis_hi  = hi_sel_q ? mem_rdata : hi_q;
  assign DataOut = {vis_hi, vis_lo};
  assign Ready   = (state_q == ST_IDLE);
  assign Done    = done_q;
  assign Error   = err_q;

  assign op_ok     = MemoryRead ^ MemoryWrite;
  assign in_range  = Wide ? (Address < LIMIT_WIDE) : (Address < LIMIT_SINGLE);
  assign accept_ok = op_ok && in_range;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hi_wdata_d = hi_wdata_q;
    rd_d       = rd_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    lo_d       = lo_q;
    hi_d       = hi_q;
    lo_sel_d   = lo_sel_q;
    hi_sel_d   = hi_sel_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = hi_wdata_q;
    case (state_q)
      ST_IDLE: begin
        mem_addr  = Address[AW-1:0];
        mem_wdata = DataIn[DATA_W-1:0];
        if (Req) begin
          if (!accept_ok) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            mem_we = MemoryWrite;
            mem_re = MemoryRead;
            if (MemoryRead) begin
              lo_d     = vis_lo;
              hi_d     = Wide ? vis_hi : '0;
              lo_sel_d = 1'b1;
              hi_sel_d = 1'b0;
            end
            if (Wide) begin
              state_d    = ST_SECOND;
              addr_d     = Address[AW-1:0] + AW'(1);
              hi_wdata_d = DataIn[2*DATA_W-1:DATA_W];
              rd_d       = MemoryRead;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      ST_SECOND: begin
        mem_we  = !rd_q;
        mem_re  = rd_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (rd_q) begin
          lo_d     = vis_lo;
          hi_d     = vis_hi;
          lo_sel_d = 1'b0;
          hi_sel_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      hi_wdata_q <= '0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      lo_sel_q   <= 1'b0;
      hi_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hi_wdata_q <= hi_wdata_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
      err_q      <= err_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      lo_sel_q   <= lo_sel_d;
      hi_sel_q   <= hi_sel_d;
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a transaction-level model checked every
// cycle, plus literal expectations taken from the access scenarios.
module tb_data_memory_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, mrd = 1'b0, mwr = 1'b0, wide = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        ready, done, error;

  int total = 0;
  int bad = 0;

  data_memory_ctrl dut (
    .Clk(clk), .Rst_n(rst_n), .Req(req), .MemoryRead(mrd), .MemoryWrite(mwr),
    .Wide(wide), .Address(addr), .DataIn(din), .DataOut(dout),
    .Ready(ready), .Done(done), .Error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: memory contents and the outcome each accepted request must have.
  logic [15:0] mem_m [2048];
  logic        busy_m = 1'b0, brd_m = 1'b0;
  logic [10:0] baddr_m = '0;
  logic [15:0] bhi_m = '0;
  logic        exp_done = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_dout = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_dout = '0;
    end else begin
      exp_done = 1'b0; exp_err = 1'b0;
      if (busy_m) begin
        busy_m = 1'b0;
        exp_done = 1'b1;
        if (brd_m) exp_dout[31:16] = mem_m[baddr_m + 11'd1];
        else mem_m[baddr_m + 11'd1] = bhi_m;
      end else if (req) begin
        if (mrd == mwr || addr >= (wide ? 32'd2047 : 32'd2048)) begin
          exp_done = 1'b1; exp_err = 1'b1;
        end else if (!wide) begin
          exp_done = 1'b1;
          if (mrd) exp_dout = {16'h0000, mem_m[addr[10:0]]};
          else mem_m[addr[10:0]] = din[15:0];
        end else begin
          busy_m = 1'b1; brd_m = mrd; baddr_m = addr[10:0]; bhi_m = din[31:16];
          if (mrd) exp_dout[15:0] = mem_m[addr[10:0]];
          else mem_m[addr[10:0]] = din[15:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_ready", {31'd0, ready}, {31'd0, !busy_m});
      chk("cyc_done", {31'd0, done}, {31'd0, exp_done});
      chk("cyc_error", {31'd0, error}, {31'd0, exp_err});
      chk("cyc_dout", dout, exp_dout);
    end
  end

  task automatic drive(input logic r, input logic rd, input logic wr, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; mrd = rd; mwr = wr; wide = w; addr = a; din = d;
    if (r) $display("txn req rd=%0b wr=%0b wide=%0b addr=%0d din=%h", rd, wr, w, a, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    step(); step();
    rst_n = 1'b1;

    // 1: write then read back-to-back, one-cycle latency
    drive(1, 0, 1, 0, 32'd1, 32'h0000FFFF); step();
    drive(1, 1, 0, 0, 32'd1, 32'd0); step();
    idle();
    chk("t1_dout", dout, 32'h0000FFFF);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_err", {31'd0, error}, 32'd0);

    // 2: overwrite and retention, including the last address
    drive(1, 0, 1, 0, 32'd8, 32'h00000DDF); step();
    drive(1, 0, 1, 0, 32'd2047, 32'h0000EB5A); step();
    drive(1, 0, 1, 0, 32'd1, 32'h00001234); step();
    drive(1, 1, 0, 0, 32'd8, 32'd0); step();
    chk("t2_r8", dout, 32'h00000DDF);
    drive(1, 1, 0, 0, 32'd2047, 32'd0); step();
    chk("t2_r2047", dout, 32'h0000EB5A);
    drive(1, 1, 0, 0, 32'd1, 32'd0); step();
    chk("t2_r1", dout, 32'h00001234);
    idle(); step();

    // 3: wide write; inputs changed during the second cycle must be ignored
    drive(1, 0, 1, 1, 32'd100, 32'hAABBCCDD); step();
    drive(1, 1, 1, 0, 32'd5, 32'hDEADBEEF);
    chk("t3_ready_busy", {31'd0, ready}, 32'd0);
    chk("t3_done_early", {31'd0, done}, 32'd0);
    step(); idle();
    chk("t3_wdone", {31'd0, done}, 32'd1);
    drive(1, 1, 0, 0, 32'd100, 32'd0); step();
    chk("t3_lo", dout, 32'h0000CCDD);
    drive(1, 1, 0, 0, 32'd101, 32'd0); step();
    chk("t3_hi", dout, 32'h0000AABB);
    drive(1, 1, 0, 1, 32'd100, 32'd0); step();
    idle();
    chk("t3_rd_mid_done", {31'd0, done}, 32'd0);
    step();
    chk("t3_wide_rd", dout, 32'hAABBCCDD);
    chk("t3_wide_done", {31'd0, done}, 32'd1);
    step();

    // 4: range errors
    drive(1, 1, 0, 0, 32'd2048, 32'd0); step(); idle();
    chk("t4_err", {31'd0, error}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_hold", dout, 32'hAABBCCDD);
    drive(1, 0, 1, 1, 32'd2047, 32'h99998888); step(); idle();
    chk("t4_werr", {31'd0, error}, 32'd1);
    chk("t4_wready", {31'd0, ready}, 32'd1);
    drive(1, 1, 0, 0, 32'd2047, 32'd0); step(); idle();
    chk("t4_2047", dout, 32'h0000EB5A);
    drive(1, 1, 0, 0, 32'h80000001, 32'd0); step(); idle();
    chk("t4_nowrap", {31'd0, error}, 32'd1);

    // 5: illegal opcode combinations
    drive(1, 0, 1, 0, 32'd5, 32'h00000505); step();
    drive(1, 1, 1, 0, 32'd5, 32'h00007777); step(); idle();
    chk("t5_both_err", {31'd0, error}, 32'd1);
    drive(1, 1, 0, 0, 32'd5, 32'd0); step(); idle();
    chk("t5_m5", dout, 32'h00000505);
    drive(1, 0, 0, 0, 32'd5, 32'd0); step(); idle();
    chk("t5_none_err", {31'd0, error}, 32'd1);
    chk("t5_none_hold", dout, 32'h00000505);

    // 6: reset in the middle of a wide write
    drive(1, 0, 1, 0, 32'd11, 32'h00005A5A); step();
    drive(1, 0, 1, 1, 32'd10, 32'h11112222); step(); idle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_dout", dout, 32'd0);
    chk("t6_ready", {31'd0, ready}, 32'd1);
    chk("t6_done", {31'd0, done}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("t6_nodone", {31'd0, done}, 32'd0);
    chk("t6_model_m10", {16'd0, mem_m[10]}, 32'h00002222);
    drive(1, 1, 0, 0, 32'd10, 32'd0); step();
    chk("t6_m10", dout, 32'h00002222);
    drive(1, 1, 0, 0, 32'd11, 32'd0); step(); idle();
    chk("t6_m11", dout, 32'h00005A5A);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
